// File: rtl/cpu_writeback.sv
// Write-back stage: merges ALU results with in-order load returns into the register-file write port.
// Optional performance counters are compiled in when WB_PERF_EN is defined.
module cpu_writeback #(
    parameter int LQ_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            ld_issue,
    input  logic [4:0]      ld_rd,
    output logic            ld_issue_ready,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_data,
    output logic [4:0]      addrw,
    output logic            writeen,
    output logic [XLEN-1:0] writeint,
    output logic [31:0]     busy_mask,
`ifdef WB_PERF_EN
    output logic [31:0]     perf_alu_stall,
    output logic [31:0]     perf_ld_wb,
`endif
    output logic            ld_err
);

    localparam int PW = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW+1)'(LQ_DEPTH);

    // Tag queue storage; every entry is visible so the busy scoreboard can see it.
    logic [4:0]          tag_reg [LQ_DEPTH];
    logic [LQ_DEPTH-1:0] vld_reg;
    logic [PW-1:0]       wr_ptr_reg;
    logic [PW-1:0]       rd_ptr_reg;
    logic [PW:0]         count_reg;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        alu_accept;
    logic [4:0]  head_tag;
    logic [31:0] entry_hot [LQ_DEPTH];

    assign full           = (count_reg == DEPTH_C);
    assign empty          = (count_reg == '0);
    assign ld_issue_ready = !full || ld_valid;
    assign push           = ld_issue && ld_issue_ready;
    assign pop            = ld_valid && !empty;
    assign head_tag       = tag_reg[rd_ptr_reg];
    assign alu_ready      = !ld_valid && !busy_mask[alu_rd];
    assign alu_accept     = alu_valid && alu_ready;

    // One-hot decode of each live entry's destination.
    generate
        for (genvar gi = 0; gi < LQ_DEPTH; gi++) begin : g_entry_hot
            assign entry_hot[gi] = vld_reg[gi] ? (32'd1 << ld_tag_shift(tag_reg[gi])) : 32'd0;
        end
    endgenerate

    function automatic logic [4:0] ld_tag_shift(input logic [4:0] t);
        return t;
    endfunction

    // x0 is never reported busy so an ALU write to x0 can't stall.
    always_comb begin
        busy_mask = 32'd0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            busy_mask = busy_mask | entry_hot[i];
        end
        busy_mask[0] = 1'b0;
    end

    // Queue entries: a push into the slot being popped (full queue) must win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                tag_reg[i] <= 5'd0;
            end
        end else begin
            if (pop) begin
                vld_reg[rd_ptr_reg] <= 1'b0;
            end
            if (push) begin
                vld_reg[wr_ptr_reg] <= 1'b1;
                tag_reg[wr_ptr_reg] <= ld_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Registered write port; a destination of x0 completes the handshake but never writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addrw    <= 5'd0;
            writeen  <= 1'b0;
            writeint <= '0;
        end else if (pop) begin
            addrw    <= head_tag;
            writeen  <= (head_tag != 5'd0);
            writeint <= ld_data;
        end else if (alu_accept) begin
            addrw    <= alu_rd;
            writeen  <= (alu_rd != 5'd0);
            writeint <= alu_data;
        end else begin
            writeen  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_err <= 1'b0;
        end else if (ld_valid && empty) begin
            ld_err <= 1'b1;
        end
    end

`ifdef WB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_alu_stall <= 32'd0;
            perf_ld_wb     <= 32'd0;
        end else begin
            if (alu_valid && !alu_ready) begin
                perf_alu_stall <= perf_alu_stall + 32'd1;
            end
            if (pop) begin
                perf_ld_wb <= perf_ld_wb + 32'd1;
            end
        end
    end
`endif

endmodule
